// File: rtl/sw_hit_encoder_if.sv
// Switch inputs and hit-event valid/ready handshake of sw_hit_encoder.
// master = the encoder, slave = the consumer (game FSM / bench).
interface sw_hit_encoder_if #(
  parameter int N_SW = 5
);
  logic [N_SW-1:0] sw_raw;
  logic [N_SW-1:0] sw_clean;
  logic            hit_valid;
  logic            hit_ready;
  logic [2:0]      hit_idx;
  logic [N_SW-1:0] hit_onehot;
  logic            multi_press;
  logic            overrun;

  modport master (
    input  sw_raw, hit_ready,
    output sw_clean, hit_valid, hit_idx, hit_onehot, multi_press, overrun
  );

  modport slave (
    output sw_raw, hit_ready,
    input  sw_clean, hit_valid, hit_idx, hit_onehot, multi_press, overrun
  );
endinterface

// File: rtl/sw_hit_encoder.sv
// Synchronises, debounces and rise-detects the player switches, then hands out
// one hit event at a time over a valid/ready handshake.
module sw_hit_encoder #(
  parameter int N_SW            = 5,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input logic              clk,
  input logic              reset,
  sw_hit_encoder_if.master bus
);
  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_SW-1:0] r_sync1, r_sync2, r_clean_d;
  logic [N_SW-1:0] w_clean, w_rise, w_rise_onehot;
  logic [2:0]      w_rise_idx;
  logic            w_rise_multi;

  state_t          r_state, w_state_next;
  logic [2:0]      r_idx, w_idx_next;
  logic [N_SW-1:0] r_onehot, w_onehot_next;
  logic            r_multi, w_multi_next;
  logic            r_overrun, w_overrun_next;
  logic            w_accept;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_clean_d <= '0;
    end else begin
      r_sync1   <= bus.sw_raw;
      r_sync2   <= r_sync1;
      r_clean_d <= w_clean;
    end
  end

  // Any return of the synced level to the clean level restarts the count.
  genvar gi;
  generate
    for (gi = 0; gi < N_SW; gi++) begin : g_deb
      logic [CNT_W-1:0] r_cnt;
      logic             r_lvl;

      always_ff @(posedge clk) begin
        if (!reset) begin
          r_cnt <= '0;
          r_lvl <= 1'b0;
        end else if (r_sync2[gi] == r_lvl) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_lvl <= r_sync2[gi];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_clean[gi] = r_lvl;
    end
  endgenerate

  assign w_rise        = w_clean & ~r_clean_d;
  // Isolating the lowest set bit gives the lowest-index-wins one-hot directly.
  assign w_rise_onehot = w_rise & ~(w_rise - N_SW'(1));
  assign w_rise_multi  = (w_rise & (w_rise - N_SW'(1))) != '0;

  always_comb begin
    w_rise_idx = 3'd0;
    for (int i = N_SW - 1; i >= 0; i--) begin
      if (w_rise[i]) w_rise_idx = 3'(i);
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_idx_next     = r_idx;
    w_onehot_next  = r_onehot;
    w_multi_next   = r_multi;
    w_overrun_next = 1'b0;
    w_accept       = (r_state == PEND) && bus.hit_ready;
    case (r_state)
      IDLE: begin
        if (|w_rise) begin
          w_idx_next    = w_rise_idx;
          w_onehot_next = w_rise_onehot;
          w_multi_next  = w_rise_multi;
          w_state_next  = PEND;
        end
      end
      PEND: begin
        if (w_accept) begin
          if (|w_rise) begin
            w_idx_next    = w_rise_idx;
            w_onehot_next = w_rise_onehot;
            w_multi_next  = w_rise_multi;
          end else begin
            w_state_next = IDLE;
          end
        end else if (|w_rise) begin
          w_overrun_next = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_idx     <= 3'd0;
      r_onehot  <= '0;
      r_multi   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_idx     <= w_idx_next;
      r_onehot  <= w_onehot_next;
      r_multi   <= w_multi_next;
      r_overrun <= w_overrun_next;
    end
  end

  assign bus.sw_clean    = w_clean;
  assign bus.hit_valid   = (r_state == PEND);
  assign bus.hit_idx     = r_idx;
  assign bus.hit_onehot  = r_onehot;
  assign bus.multi_press = r_multi;
  assign bus.overrun     = r_overrun;
endmodule

// File: tb/tb_sw_hit_encoder.sv
// Directed scenarios plus random bouncing switches, every cycle compared against
// a history-window reference model of debounce and event handling.
module tb_sw_hit_encoder;
  localparam int N_SW  = 5;
  localparam int DEB   = 4;
  localparam int CNT_W = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  sw_hit_encoder_if #(.N_SW(N_SW)) bus ();

  sw_hit_encoder #(
    .N_SW(N_SW), .DEBOUNCE_CYCLES(DEB), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [N_SW-1:0] m_raw_q[$];   // raw samples still travelling through the synchroniser
  logic [N_SW-1:0] m_s_hist[$];  // last DEB synced levels
  logic [N_SW-1:0] m_clean, m_clean_prev, m_onehot;
  logic [2:0]      m_idx;
  logic            m_valid, m_multi, m_overrun;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_raw_q.delete();
    m_raw_q.push_back('0);
    m_raw_q.push_back('0);
    m_s_hist.delete();
    m_clean = '0; m_clean_prev = '0; m_onehot = '0;
    m_idx = 3'd0; m_valid = 1'b0; m_multi = 1'b0; m_overrun = 1'b0;
  endtask

  task automatic model_load(input logic [N_SW-1:0] rise);
    int n;
    n = 0;
    for (int i = N_SW - 1; i >= 0; i--) begin
      if (rise[i]) begin
        m_idx = 3'(i);
        n++;
      end
    end
    m_onehot = '0;
    m_onehot[m_idx] = 1'b1;
    m_multi = (n > 1);
    m_valid = 1'b1;
  endtask

  // One clock edge: sample inputs, advance the model, compare every output.
  task automatic tick();
    logic [N_SW-1:0] raw, s_now, rise, nclean;
    logic rdy, rst_n, acc, all_diff;
    raw = bus.sw_raw; rdy = bus.hit_ready; rst_n = reset;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      s_now = m_raw_q[0];
      rise  = m_clean & ~m_clean_prev;
      acc   = m_valid && rdy;
      m_overrun = 1'b0;
      if (rise != '0) begin
        if (!m_valid || acc) model_load(rise);
        else m_overrun = 1'b1;
      end else if (acc) begin
        m_valid = 1'b0;
      end
      m_clean_prev = m_clean;
      m_s_hist.push_back(s_now);
      if (m_s_hist.size() > DEB) void'(m_s_hist.pop_front());
      nclean = m_clean;
      if (m_s_hist.size() == DEB) begin
        for (int i = 0; i < N_SW; i++) begin
          all_diff = 1'b1;
          foreach (m_s_hist[k]) if (m_s_hist[k][i] == m_clean[i]) all_diff = 1'b0;
          if (all_diff) nclean[i] = s_now[i];
        end
      end
      m_clean = nclean;
      void'(m_raw_q.pop_front());
      m_raw_q.push_back(raw);
    end
    chk("sw_clean",    bus.sw_clean,    m_clean);
    chk("hit_valid",   bus.hit_valid,   m_valid);
    chk("hit_idx",     bus.hit_idx,     m_idx);
    chk("hit_onehot",  bus.hit_onehot,  m_onehot);
    chk("multi_press", bus.multi_press, m_multi);
    chk("overrun",     bus.overrun,     m_overrun);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    logic [N_SW-1:0] v;
    int len;
    model_reset();
    bus.sw_raw = '0;
    bus.hit_ready = 1'b0;

    // Reset state
    do_reset();
    chk("rst_valid", bus.hit_valid, 0);
    chk("rst_idx", bus.hit_idx, 0);
    chk("rst_onehot", bus.hit_onehot, 0);
    chk("rst_clean", bus.sw_clean, 0);

    // 1: single switch, full latency, held while not ready
    bus.sw_raw = 5'b00100;
    repeat (6) tick();
    chk("t1_clean_edge5", bus.sw_clean, 5'b00100);
    chk("t1_novalid_edge5", bus.hit_valid, 0);
    tick();
    chk("t1_valid_edge6", bus.hit_valid, 1);
    chk("t1_idx", bus.hit_idx, 2);
    chk("t1_onehot", bus.hit_onehot, 5'b00100);
    chk("t1_multi", bus.multi_press, 0);
    repeat (5) tick();
    chk("t1_hold_valid", bus.hit_valid, 1);
    chk("t1_hold_idx", bus.hit_idx, 2);

    // 2: bounce shorter than the debounce window is ignored
    bus.sw_raw = '0;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      bus.sw_raw[1] = ~bus.sw_raw[1];
      tick();
      tick();
    end
    bus.sw_raw = '0;
    repeat (8) tick();
    chk("t2_clean", bus.sw_clean, 0);
    chk("t2_valid", bus.hit_valid, 0);

    // 3: two switches together, consumer always ready
    do_reset();
    bus.hit_ready = 1'b1;
    bus.sw_raw = 5'b01010;
    repeat (7) tick();
    chk("t3_valid", bus.hit_valid, 1);
    chk("t3_idx", bus.hit_idx, 1);
    chk("t3_onehot", bus.hit_onehot, 5'b00010);
    chk("t3_multi", bus.multi_press, 1);
    tick();
    chk("t3_drop", bus.hit_valid, 0);
    bus.hit_ready = 1'b0;

    // 4: rise while pending and not ready -> overrun pulse
    bus.sw_raw = '0;
    do_reset();
    bus.sw_raw = 5'b00001;
    repeat (7) tick();
    chk("t4_pending", bus.hit_valid, 1);
    bus.sw_raw = 5'b10001;
    for (int k = 0; k < 20 && !bus.overrun; k++) tick();
    chk("t4_overrun_seen", bus.overrun, 1);
    chk("t4_idx_kept", bus.hit_idx, 0);
    tick();
    chk("t4_overrun_pulse", bus.overrun, 0);
    bus.hit_ready = 1'b1;
    tick();
    chk("t4_accept_idle", bus.hit_valid, 0);
    bus.hit_ready = 1'b0;

    // 5: accept in the same cycle as a new rise -> no bubble
    bus.sw_raw = '0;
    do_reset();
    bus.sw_raw = 5'b00010;
    repeat (7) tick();
    chk("t5_first_idx", bus.hit_idx, 1);
    bus.sw_raw = 5'b00011;
    repeat (6) tick();
    bus.hit_ready = 1'b1;
    tick();
    chk("t5_valid", bus.hit_valid, 1);
    chk("t5_idx", bus.hit_idx, 0);
    chk("t5_overrun", bus.overrun, 0);
    bus.hit_ready = 1'b0;

    // 6: reset mid-debounce with an event pending, then full latency again
    bus.sw_raw = '0;
    do_reset();
    bus.sw_raw = 5'b00001;
    repeat (7) tick();
    bus.sw_raw = 5'b00101;
    repeat (4) tick();
    reset = 1'b0;
    tick();
    chk("t6_rst_valid", bus.hit_valid, 0);
    chk("t6_rst_clean", bus.sw_clean, 0);
    chk("t6_rst_onehot", bus.hit_onehot, 0);
    reset = 1'b1;
    repeat (6) tick();
    chk("t6_clean_again", bus.sw_clean, 5'b00101);
    chk("t6_novalid_yet", bus.hit_valid, 0);
    tick();
    chk("t6_valid_again", bus.hit_valid, 1);
    chk("t6_idx", bus.hit_idx, 0);
    chk("t6_multi", bus.multi_press, 1);

    // Random bouncing switches with random ready and rare resets
    for (int seg = 0; seg < 60; seg++) begin
      v = N_SW'($urandom_range(0, 31));
      len = $urandom_range(1, 10);
      for (int c = 0; c < len; c++) begin
        bus.sw_raw = v;
        if ($urandom_range(0, 4) == 0) bus.sw_raw[$urandom_range(0, N_SW - 1)] = ~v[0];
        bus.hit_ready = 1'($urandom_range(0, 1));
        reset = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
        tick();
      end
    end
    reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
